spi_strip_router: RTL

//  Clocked, addressed successor to the combinational act-pin SPI demux for the LED strip banks.
//  - One SPI slave stream carries frames of the form: 8-bit strip address, then N pixel bits.
//  - The block synchronises the SPI pins into clk and forwards the pixel bits only to the

---
 rtl/spi_strip_router_if.sv | 36 +++
 rtl/spi_strip_router.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_strip_router_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_strip_router_if
//  Description : Pin bundle for spi_strip_router. It carries the SPI slave
//                pins (sck, mosi, cs_n, miso) and the strip-bank outputs
//                (bank_c, bank_le, bank_d, frame_done, frame_err).
//                master : the SPI host / strip side (drives SPI pins, reads outputs)
//                slave  : the router itself
//  Revision    : 1.0  initial release
// ============================================================================
interface spi_strip_router_if #(
  parameter int NUM_BANKS       = 4,
  parameter int STRIPS_PER_BANK = 9,
  parameter int LATCH_GROUPS    = 2
);
  logic                                 spi_sck;
  logic                                 spi_mosi;
  logic                                 spi_cs_n;
  logic                                 spi_miso;
  logic [NUM_BANKS-1:0]                 bank_c;
  logic [NUM_BANKS*LATCH_GROUPS-1:0]    bank_le;
  logic [NUM_BANKS*STRIPS_PER_BANK-1:0] bank_d;
  logic                                 frame_done;
  logic                                 frame_err;

  modport master (
    output spi_sck, spi_mosi, spi_cs_n,
    input  spi_miso, bank_c, bank_le, bank_d, frame_done, frame_err
  );

  modport slave (
    input  spi_sck, spi_mosi, spi_cs_n,
    output spi_miso, bank_c, bank_le, bank_d, frame_done, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/spi_strip_router.sv
`default_nettype none
// ============================================================================
//  Module      : spi_strip_router
//  Description : Addressed SPI-to-LED-strip router. Each SPI frame is an 8-bit
//                strip address followed by pixel bits. The pixel clock and data
//                are forwarded, 3 clk behind the pins, to the addressed bank's
//                clock and data lane only; at cs_n release the matching latch
//                enable is pulsed for LATCH_CYCLES clocks.
//  Ports       : clk, rst (sync, active high)
//                bus.slave : spi_sck/spi_mosi/spi_cs_n in, spi_miso out,
//                            bank_c, bank_le, bank_d, frame_done, frame_err out
//  Options     : SPI_STRIP_ROUTER_STATUS_EN - when defined, spi_miso returns
//                {err_seen, frame_cnt[6:0]} MSB first during the address byte;
//                otherwise spi_miso is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_strip_router #(
  parameter int NUM_BANKS       = 4,
  parameter int STRIPS_PER_BANK = 9,
  parameter int LATCH_GROUPS    = 2,
  parameter int LATCH_CYCLES    = 8
) (
  input  logic              clk,
  input  logic              rst,
  spi_strip_router_if.slave bus
);
  localparam int STRIPS_PER_BANK_ALL = LATCH_GROUPS * STRIPS_PER_BANK;
  localparam int NUM_STRIPS          = NUM_BANKS * STRIPS_PER_BANK_ALL;
  localparam int NUM_LE              = NUM_BANKS * LATCH_GROUPS;
  localparam int NUM_D               = NUM_BANKS * STRIPS_PER_BANK;
  localparam int LCW                 = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_PASS  = 3'd2,
    S_LATCH = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                sck_m_q, sck_m_d, sck_s_q, sck_s_d, sck_p_q, sck_p_d;
  logic                mosi_m_q, mosi_m_d, mosi_s_q, mosi_s_d;
  logic                cs_m_q, cs_m_d, cs_s_q, cs_s_d, cs_p_q, cs_p_d;
  logic [7:0]          addr_q, addr_d;
  logic [15:0]         bit_cnt_q, bit_cnt_d;
  logic [LCW-1:0]      lat_cnt_q, lat_cnt_d;
  logic [NUM_BANKS-1:0] bank_c_q, bank_c_d;
  logic [NUM_LE-1:0]   bank_le_q, bank_le_d;
  logic [NUM_D-1:0]    bank_d_q, bank_d_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_err_q, frame_err_d;

  logic                sck_rise, cs_rise, cs_fall, fwd;
  logic [7:0]          addr_next, bank_idx, grp_idx, lane_idx, d_sel, le_sel;

  assign sck_rise  = sck_s_q & ~sck_p_q;
  assign cs_rise   = cs_s_q & ~cs_p_q;
  assign cs_fall   = ~cs_s_q & cs_p_q;
  assign addr_next = {addr_q[6:0], mosi_s_q};

  // Strip address decode; only meaningful while addr_q < NUM_STRIPS (PASS/LATCH).
  always_comb begin
    bank_idx = addr_q / 8'(STRIPS_PER_BANK_ALL);
    grp_idx  = (addr_q % 8'(STRIPS_PER_BANK_ALL)) / 8'(STRIPS_PER_BANK);
    lane_idx = addr_q % 8'(STRIPS_PER_BANK);
    d_sel    = bank_idx * 8'(STRIPS_PER_BANK) + lane_idx;
    le_sel   = bank_idx * 8'(LATCH_GROUPS) + grp_idx;
  end

  always_comb begin
    sck_m_d   = bus.spi_sck;
    sck_s_d   = sck_m_q;
    sck_p_d   = sck_s_q;
    mosi_m_d  = bus.spi_mosi;
    mosi_s_d  = mosi_m_q;
    cs_m_d    = bus.spi_cs_n;
    cs_s_d    = cs_m_q;
    cs_p_d    = cs_s_q;

    state_d     = state_q;
    addr_d      = addr_q;
    bit_cnt_d   = bit_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          state_d   = S_ADDR;
          bit_cnt_d = '0;
          addr_d    = '0;
        end
      end
      S_ADDR: begin
        if (cs_rise) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end else if (sck_rise) begin
          addr_d = addr_next;
          if (bit_cnt_q == 16'd7) begin
            bit_cnt_d = '0;
            if ({1'b0, addr_next} < 9'(NUM_STRIPS)) begin
              state_d = S_PASS;
            end else begin
              state_d     = S_ERR;
              frame_err_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 16'd1;
          end
        end
      end
      S_PASS: begin
        if (cs_rise) begin
          if (bit_cnt_q != 16'd0) begin
            state_d   = S_LATCH;
            lat_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (sck_rise && (bit_cnt_q != 16'hFFFF)) begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      S_LATCH: begin
        if (lat_cnt_q == LCW'(LATCH_CYCLES - 1)) begin
          if (cs_s_q) begin
            state_d = S_IDLE;
          end else begin
            // A new frame started while latching; it is discarded.
            state_d     = S_ERR;
            frame_err_d = 1'b1;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + LCW'(1);
        end
      end
      S_ERR: begin
        if (cs_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so LE and frame_done line up
    // with the LATCH state cycles exactly.
    fwd       = (state_q == S_PASS) && (state_d == S_PASS);
    bank_c_d  = '0;
    bank_d_d  = '0;
    bank_le_d = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      // The strip clock may only go high on a rise seen in PASS; this hides the
      // tail of the 8th address clock, which is still high on PASS entry.
      if (bank_idx == 8'(b))
        bank_c_d[b] = fwd & sck_s_q & (bank_c_q[b] | sck_rise);
    end
    for (int i = 0; i < NUM_D; i++) begin
      if (d_sel == 8'(i)) bank_d_d[i] = fwd & mosi_s_q;
    end
    for (int i = 0; i < NUM_LE; i++) begin
      if (le_sel == 8'(i)) bank_le_d[i] = (state_d == S_LATCH);
    end
    frame_done_d = (state_d == S_LATCH) && (lat_cnt_d == LCW'(LATCH_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sck_m_q      <= 1'b0;
      sck_s_q      <= 1'b0;
      sck_p_q      <= 1'b0;
      mosi_m_q     <= 1'b0;
      mosi_s_q     <= 1'b0;
      cs_m_q       <= 1'b0;
      cs_s_q       <= 1'b0;
      cs_p_q       <= 1'b0;
      addr_q       <= '0;
      bit_cnt_q    <= '0;
      lat_cnt_q    <= '0;
      bank_c_q     <= '0;
      bank_le_q    <= '0;
      bank_d_q     <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sck_m_q      <= sck_m_d;
      sck_s_q      <= sck_s_d;
      sck_p_q      <= sck_p_d;
      mosi_m_q     <= mosi_m_d;
      mosi_s_q     <= mosi_s_d;
      cs_m_q       <= cs_m_d;
      cs_s_q       <= cs_s_d;
      cs_p_q       <= cs_p_d;
      addr_q       <= addr_d;
      bit_cnt_q    <= bit_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      bank_c_q     <= bank_c_d;
      bank_le_q    <= bank_le_d;
      bank_d_q     <= bank_d_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.bank_c     = bank_c_q;
  assign bus.bank_le    = bank_le_q;
  assign bus.bank_d     = bank_d_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;

`ifdef SPI_STRIP_ROUTER_STATUS_EN
  logic       sck_fall;
  logic [6:0] frame_cnt_q, frame_cnt_d;
  logic       err_seen_q, err_seen_d;
  logic [7:0] miso_sr_q, miso_sr_d;
  logic       spi_miso_q, spi_miso_d;

  assign sck_fall = ~sck_s_q & sck_p_q;

  always_comb begin
    frame_cnt_d = frame_done_d ? frame_cnt_q + 7'd1 : frame_cnt_q;
    miso_sr_d   = miso_sr_q;
    err_seen_d  = err_seen_q;
    if ((state_q == S_IDLE) && (state_d == S_ADDR)) begin
      miso_sr_d  = {err_seen_q, frame_cnt_q};
      err_seen_d = 1'b0;
    end else if ((state_q == S_ADDR) && sck_fall) begin
      // Zero fill: after 8 shifts the line reads 0 for the rest of ADDR.
      miso_sr_d = {miso_sr_q[6:0], 1'b0};
    end
    if (frame_err_d) err_seen_d = 1'b1;
    spi_miso_d = (state_d == S_ADDR) & miso_sr_d[7];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      err_seen_q  <= 1'b0;
      miso_sr_q   <= '0;
      spi_miso_q  <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_seen_q  <= err_seen_d;
      miso_sr_q   <= miso_sr_d;
      spi_miso_q  <= spi_miso_d;
    end
  end

  assign bus.spi_miso = spi_miso_q;
`else
  assign bus.spi_miso = 1'b0;
`endif

endmodule
`default_nettype wire
